// File: rtl/convert_integer_to_floatingpoint_seq.sv
// Iterative signed-integer to IEEE-754 single converter: one leading-zero shift per cycle.
// Optional build macro ROUND_NEAREST_EN selects round-to-nearest-even; without it the result is truncated.
module convert_integer_to_floatingpoint_seq #(
    parameter int INT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [INT_WIDTH-1:0] Int,
    output logic                 ready_out,
    output logic [31:0]          FP,
    output logic                 valid_out
);

    localparam int CNT_W = $clog2(INT_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NORM = 2'd1;
    localparam logic [1:0] S_PACK = 2'd2;

    localparam logic [7:0]           EXP_TOP = 8'(127 + INT_WIDTH - 1);
    localparam logic [INT_WIDTH-1:0] MAG_ONE = INT_WIDTH'(1);
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);

    logic [1:0]           state_reg, state_next;
    logic [INT_WIDTH-1:0] mag_reg, mag_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 sign_reg, sign_next;
    logic [31:0]          fp_reg, fp_next;
    logic                 valid_reg, valid_next;

    logic [22:0] mant_trunc;
    logic        round_up;
    logic [23:0] mant_sum;
    logic [7:0]  exp_calc;
    logic [31:0] pack_word;

    // Mantissa field: the bits just below the (implicit) leading one of the normalised magnitude.
    generate
        if (INT_WIDTH >= 24) begin : g_mant_wide
            assign mant_trunc = mag_reg[INT_WIDTH-2 -: 23];
        end else begin : g_mant_narrow
            assign mant_trunc = {mag_reg[INT_WIDTH-2:0], {(24-INT_WIDTH){1'b0}}};
        end
    endgenerate

`ifdef ROUND_NEAREST_EN
    logic guard_bit;
    logic sticky_bit;

    generate
        if (INT_WIDTH >= 26) begin : g_round_full
            assign guard_bit  = mag_reg[INT_WIDTH-25];
            assign sticky_bit = |mag_reg[INT_WIDTH-26:0];
        end else if (INT_WIDTH == 25) begin : g_round_guard
            assign guard_bit  = mag_reg[0];
            assign sticky_bit = 1'b0;
        end else begin : g_round_none
            assign guard_bit  = 1'b0;
            assign sticky_bit = 1'b0;
        end
    endgenerate

    assign round_up = guard_bit & (sticky_bit | mant_trunc[0]);
`else
    assign round_up = 1'b0;
`endif

    // A carry out of the 23-bit field leaves mant_sum[22:0] at zero and bumps the exponent.
    assign mant_sum  = {1'b0, mant_trunc} + 24'(round_up);
    assign exp_calc  = EXP_TOP - 8'(cnt_reg) + 8'(mant_sum[23]);
    assign pack_word = (mag_reg == '0) ? 32'h0000_0000
                                       : {sign_reg, exp_calc, mant_sum[22:0]};

    always_comb begin
        state_next = state_reg;
        mag_next   = mag_reg;
        cnt_next   = cnt_reg;
        sign_next  = sign_reg;
        fp_next    = fp_reg;
        valid_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (valid_in) begin
                    // Two's-complement negate; the most negative value maps to 2^(INT_WIDTH-1).
                    sign_next  = Int[INT_WIDTH-1];
                    mag_next   = Int[INT_WIDTH-1] ? (~Int + MAG_ONE) : Int;
                    cnt_next   = '0;
                    state_next = S_NORM;
                end
            end
            S_NORM: begin
                if ((mag_reg == '0) || mag_reg[INT_WIDTH-1]) begin
                    state_next = S_PACK;
                end else begin
                    mag_next = mag_reg << 1;
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            S_PACK: begin
                fp_next    = pack_word;
                valid_next = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            mag_reg   <= '0;
            cnt_reg   <= '0;
            sign_reg  <= 1'b0;
            fp_reg    <= 32'h0000_0000;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            mag_reg   <= mag_next;
            cnt_reg   <= cnt_next;
            sign_reg  <= sign_next;
            fp_reg    <= fp_next;
            valid_reg <= valid_next;
        end
    end

    assign ready_out = (state_reg == S_IDLE);
    assign FP        = fp_reg;
    assign valid_out = valid_reg;

endmodule

// File: tb/tb_convert_integer_to_floatingpoint_seq.sv
// Directed bench for convert_integer_to_floatingpoint_seq (INT_WIDTH=32); expectations follow ROUND_NEAREST_EN.
module tb_convert_integer_to_floatingpoint_seq;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] Int;
    logic        ready_out;
    logic [31:0] FP;
    logic        valid_out;

    int checks;
    int failures;

    convert_integer_to_floatingpoint_seq #(.INT_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .Int       (Int),
        .ready_out (ready_out),
        .FP        (FP),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after the accepting edge; returns #1 after the edge that raises valid_out.
    task automatic wait_result(input string tag, input logic [31:0] exp_fp, input int exp_lat);
        int  lat;
        bit  got;
        bit  ready_bad;
        lat       = 0;
        got       = 1'b0;
        ready_bad = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid_out) got = 1'b1;
            else if (ready_out) ready_bad = 1'b1;
        end
        check({tag, "_valid_seen"}, 32'(got), 32'd1);
        check({tag, "_ready_low"},  32'(ready_bad), 32'd0);
        check({tag, "_latency"},    32'(lat), 32'(exp_lat));
        check({tag, "_fp"},         FP, exp_fp);
        check({tag, "_ready_back"}, 32'(ready_out), 32'd1);
        $display("txn %s: FP=%h latency=%0d", tag, FP, lat);
    endtask

    task automatic convert(input string tag, input logic [31:0] val,
                           input logic [31:0] exp_fp, input int exp_lat);
        @(negedge clk);
        Int      = val;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        wait_result(tag, exp_fp, exp_lat);
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, 32'(valid_out), 32'd0);
        check({tag, "_fp_hold"},   FP, exp_fp);
    endtask

    initial begin
        int quiet_bad;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        valid_in = 1'b0;
        Int      = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(ready_out), 32'd1);
        check("reset_valid", 32'(valid_out), 32'd0);
        check("reset_fp",    FP, 32'h0000_0000);
        rst = 1'b0;

        convert("one",       32'd1,          32'h3F80_0000, 33);
        convert("minus_one", 32'hFFFF_FFFF,  32'hBF80_0000, 33);
        convert("hundred",   32'd100,        32'h42C8_0000, 27);
        convert("minus_100", -32'sd100,      32'hC2C8_0000, 27);
        convert("zero",      32'd0,          32'h0000_0000, 2);
        convert("most_neg",  32'h8000_0000,  32'hCF00_0000, 2);
`ifdef ROUND_NEAREST_EN
        convert("max_pos",   32'h7FFF_FFFF,  32'h4F00_0000, 3);
        convert("tie_odd",   32'd16777219,   32'h4B80_0002, 9);
`else
        convert("max_pos",   32'h7FFF_FFFF,  32'h4EFF_FFFF, 3);
        convert("tie_odd",   32'd16777219,   32'h4B80_0001, 9);
`endif
        convert("tie_even",  32'd16777217,   32'h4B80_0000, 9);

        // valid_in held high during a conversion: the second word waits for ready_out.
        @(negedge clk);
        Int      = 32'd1;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        Int = 32'd5;
        wait_result("hold_first", 32'h3F80_0000, 33);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check("hold_accept_busy", 32'(ready_out), 32'd0);
        check("hold_no_repeat",   32'(valid_out), 32'd0);
        wait_result("hold_second", 32'h40A0_0000, 31);

        // Asynchronous reset mid-normalisation discards the in-flight word.
        @(negedge clk);
        Int      = 32'd1;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_ready", 32'(ready_out), 32'd1);
        check("arst_valid", 32'(valid_out), 32'd0);
        check("arst_fp",    FP, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        quiet_bad = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (valid_out || !ready_out) quiet_bad++;
        end
        check("arst_no_result", 32'(quiet_bad), 32'd0);
        $display("txn arst: idle cycles with bad status=%0d", quiet_bad);
        convert("after_rst", 32'd2, 32'h4000_0000, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
